// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues fixed-latency fetches and buffers the
// returned words; the buffer head is the IF/ID register presented to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      pc_reg, pc_next;
    logic             inflight_reg;
    logic [31:0]      inflight_pc_reg;
    logic             drop_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;

    logic [31:0] instr_mem [FIFO_DEPTH];
    logic [31:0] pc_mem    [FIFO_DEPTH];

    logic [CNT_W:0] occupancy;
    logic           accept;
    logic           push;
    logic           pop;

    // Reserve a slot for the in-flight word so a push can never overflow the buffer.
    assign occupancy = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    assign imem_req  = rst_n & ~redirect_valid & (occupancy < DEPTH_C);
    assign imem_addr = pc_reg;

    assign accept = imem_req & imem_gnt;
    assign push   = inflight_reg & imem_rvalid & ~drop_reg & ~redirect_valid;
    assign pop    = id_valid & ~id_stall & ~redirect_valid;

    assign id_valid = (count_reg != '0);
    assign id_instr = id_valid ? instr_mem[rd_ptr_reg] : NOP_INSTR;
    assign id_pc    = id_valid ? pc_mem[rd_ptr_reg] : 32'h0000_0000;

    always_comb begin
        pc_next     = pc_reg;
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (redirect_valid) begin
            pc_next     = redirect_pc & 32'hFFFF_FFFC;
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            if (accept) begin
                pc_next = pc_reg + 32'd4;
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= 32'h0000_0000;
            drop_reg        <= 1'b0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            pc_reg       <= pc_next;
            inflight_reg <= accept;
            if (accept) begin
                inflight_pc_reg <= pc_reg;
            end
            // A response missing at redirect time must not be taken for a new-stream word.
            drop_reg   <= redirect_valid & inflight_reg & ~imem_rvalid;
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    // Entries past the occupancy count are never presented, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based model of the fetch stream is checked
// against the DUT every cycle, with literal expectations pinning key cycles.
module tb_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH),
        .NOP_INSTR  (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          data_mode = 1'b0;
    bit          mem_pend  = 1'b0;
    logic [31:0] mem_pend_addr = 32'h0;

    ent_t        m_buf[$];
    logic [31:0] m_pc;
    logic [31:0] m_infl_pc;
    bit          m_infl;

    // Mode 0: same word everywhere; mode 1: word encodes its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!data_mode) return 32'h00A0_0093;
        return (a << 8) | 32'h0000_0013;
    endfunction

    function automatic bit model_req();
        return (rst_n === 1'b1) && (redirect_valid !== 1'b1) &&
               ((m_buf.size() + int'(m_infl)) < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%08h want=%08h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_infl    = 1'b0;
        m_infl_pc = 32'h0;
        m_pc      = 32'h0;
    endtask

    task automatic check_outputs();
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        e_valid = (m_buf.size() > 0);
        e_instr = e_valid ? m_buf[0].instr : 32'h0000_0013;
        e_pc    = e_valid ? m_buf[0].pc : 32'h0;
        chk("imem_req",  32'(imem_req), 32'(model_req()));
        chk("imem_addr", imem_addr, m_pc);
        chk("id_valid",  32'(id_valid), 32'(e_valid));
        chk("id_instr",  id_instr, e_instr);
        chk("id_pc",     id_pc, e_pc);
    endtask

    task automatic model_advance(input bit g, input bit st, input bit rv, input logic [31:0] rp);
        bit req;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        req = model_req();
        if (rv) begin
            $display("redirect cyc=%0d to %08h (flushing %0d entries)", cyc, rp, m_buf.size());
            m_buf.delete();
            m_infl = 1'b0;
            m_pc   = {rp[31:2], 2'b00};
            return;
        end
        if (m_buf.size() > 0 && !st) begin
            $display("retire cyc=%0d pc=%08h instr=%08h", cyc, m_buf[0].pc, m_buf[0].instr);
            void'(m_buf.pop_front());
        end
        if (m_infl && imem_rvalid === 1'b1) begin
            m_buf.push_back('{instr: mem_word(m_infl_pc), pc: m_infl_pc});
        end
        m_infl = 1'b0;
        if (req && g) begin
            m_infl    = 1'b1;
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd4;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic step(input bit g, input bit st, input bit rv, input logic [31:0] rp, input bit lose);
        @(negedge clk);
        imem_gnt       = g;
        id_stall       = st;
        redirect_valid = rv;
        redirect_pc    = rp;
        imem_rvalid    = mem_pend && !lose;
        imem_rdata     = mem_pend ? mem_word(mem_pend_addr) : 32'hDEAD_BEEF;
        #1;
        check_outputs();
        mem_pend      = (imem_req === 1'b1) && g;
        mem_pend_addr = imem_addr;
        model_advance(g, st, rv, rp);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Called away from clock edges so the reset assertion is genuinely asynchronous.
    task automatic do_reset();
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        mem_pend       = 1'b0;
        model_reset();
        cyc = 0;
        #1;
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, 32'h0000_0013);
        chk("rst_pc",    id_pc, 32'h0);
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b1;
        imem_gnt       = 1'b0;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        model_reset();
        #2;

        // 1: reset release and basic stream with a constant instruction word
        data_mode = 1'b0;
        do_reset();
        step(1, 0, 0, 32'h0, 0);
        chk("t1_c0_addr", imem_addr, 32'h0);
        chk("t1_c0_req", 32'(imem_req), 32'd1);
        step(1, 0, 0, 32'h0, 0);
        chk("t1_c1_addr", imem_addr, 32'h4);
        step(1, 0, 0, 32'h0, 0);
        chk("t1_c2_valid", 32'(id_valid), 32'd1);
        chk("t1_c2_pc", id_pc, 32'h0);
        chk("t1_c2_instr", id_instr, 32'h00A0_0093);
        chk("t1_c2_req", 32'(imem_req), 32'd0);
        step(1, 0, 0, 32'h0, 0);
        chk("t1_c3_pc", id_pc, 32'h4);
        chk("t1_c3_addr", imem_addr, 32'h8);
        run(6);

        // 2: stall from cycle 3 fills buffer plus in-flight slot, head holds
        data_mode = 1'b1;
        do_reset();
        run(3);
        step(1, 1, 0, 32'h0, 0);
        step(1, 1, 0, 32'h0, 0);
        step(1, 1, 0, 32'h0, 0);
        chk("t2_c5_req", 32'(imem_req), 32'd0);
        chk("t2_c5_pc", id_pc, 32'h4);
        chk("t2_c5_instr", id_instr, 32'h0000_0413);
        step(1, 1, 0, 32'h0, 0);
        step(1, 1, 0, 32'h0, 0);
        chk("t2_c7_pc", id_pc, 32'h4);
        chk("t2_c7_valid", 32'(id_valid), 32'd1);
        run(8);

        // 3: grant withheld at 0x8, then a missing response (protocol error)
        do_reset();
        run(3);
        step(0, 0, 0, 32'h0, 0);
        chk("t3_c3_addr", imem_addr, 32'h8);
        step(0, 0, 0, 32'h0, 0);
        chk("t3_c4_addr", imem_addr, 32'h8);
        chk("t3_c4_valid", 32'(id_valid), 32'd0);
        chk("t3_c4_instr", id_instr, 32'h0000_0013);
        step(0, 0, 0, 32'h0, 0);
        chk("t3_c5_addr", imem_addr, 32'h8);
        step(1, 0, 0, 32'h0, 0);
        chk("t3_c6_addr", imem_addr, 32'h8);
        step(1, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 1);
        chk("t3_c8_pc", id_pc, 32'h8);
        step(1, 0, 0, 32'h0, 0);
        chk("t3_c9_valid", 32'(id_valid), 32'd0);
        chk("t3_c9_addr", imem_addr, 32'h10);
        step(1, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);
        chk("t3_c11_pc", id_pc, 32'h10);
        run(4);

        // 4: redirect to 0x101 with an entry buffered and a fetch in flight
        do_reset();
        run(3);
        step(1, 1, 0, 32'h0, 0);
        step(1, 1, 1, 32'h0000_0101, 0);
        chk("t4_R_req", 32'(imem_req), 32'd0);
        step(1, 0, 0, 32'h0, 0);
        chk("t4_R1_valid", 32'(id_valid), 32'd0);
        chk("t4_R1_addr", imem_addr, 32'h100);
        step(1, 0, 0, 32'h0, 0);
        chk("t4_R2_valid", 32'(id_valid), 32'd0);
        step(1, 0, 0, 32'h0, 0);
        chk("t4_R3_pc", id_pc, 32'h100);
        chk("t4_R3_instr", id_instr, 32'h0001_0013);
        run(4);

        // 5: redirect and stall in the same cycle, stall kept for a few cycles
        do_reset();
        run(2);
        step(1, 1, 1, 32'h2000_0040, 0);
        chk("t5_R_valid", 32'(id_valid), 32'd1);
        chk("t5_R_req", 32'(imem_req), 32'd0);
        step(1, 1, 0, 32'h0, 0);
        chk("t5_R1_valid", 32'(id_valid), 32'd0);
        chk("t5_R1_addr", imem_addr, 32'h2000_0040);
        step(1, 1, 0, 32'h0, 0);
        step(1, 1, 0, 32'h0, 0);
        chk("t5_R3_pc", id_pc, 32'h2000_0040);
        chk("t5_R3_instr", id_instr, 32'h0000_4013);
        run(6);

        // 7: PC wraps past the top of the address space
        step(1, 0, 1, 32'hFFFF_FFFB, 0);
        step(1, 0, 0, 32'h0, 0);
        chk("t7_R1_addr", imem_addr, 32'hFFFF_FFF8);
        step(1, 0, 0, 32'h0, 0);
        chk("t7_R2_addr", imem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 32'h0, 0);
        chk("t7_R3_pc", id_pc, 32'hFFFF_FFF8);
        step(1, 0, 0, 32'h0, 0);
        chk("t7_R4_addr", imem_addr, 32'h0);
        chk("t7_R4_pc", id_pc, 32'hFFFF_FFFC);
        run(4);

        // 6: asynchronous reset mid-stream, then restart at the reset PC
        do_reset();
        step(1, 0, 0, 32'h0, 0);
        chk("t6_c0_addr", imem_addr, 32'h0);
        chk("t6_c0_req", 32'(imem_req), 32'd1);
        step(1, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);
        chk("t6_c2_valid", 32'(id_valid), 32'd1);
        chk("t6_c2_pc", id_pc, 32'h0);
        run(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
